// File: rtl/display_scan_ctrl_pkg.sv
// Shared definitions for the display scan controller.
// Segment byte layout is {A,B,C,D,E,F,G,DP}, active-high, bit 7 = A.
package display_scan_ctrl_pkg;

    // Segment patterns for the decimal digits (DP bit always clear here)
    localparam logic [7:0] SEG_0   = 8'hFC;
    localparam logic [7:0] SEG_1   = 8'h60;
    localparam logic [7:0] SEG_2   = 8'hDA;
    localparam logic [7:0] SEG_3   = 8'hF2;
    localparam logic [7:0] SEG_4   = 8'h66;
    localparam logic [7:0] SEG_5   = 8'hB6;
    localparam logic [7:0] SEG_6   = 8'hBE;
    localparam logic [7:0] SEG_7   = 8'hE0;
    localparam logic [7:0] SEG_8   = 8'hFE;
    localparam logic [7:0] SEG_9   = 8'hF6;
    localparam logic [7:0] SEG_OFF = 8'h00;

    // Position of the decimal point inside the segment byte
    localparam int SEG_DP_BIT = 0;

    // Scan sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } scan_state_e;

endpackage

// File: rtl/bcd7seg_dec.sv
// BCD to 7-segment decoder. Pure combinational; codes 10..15 light nothing.
// The DP bit of the output is always clear; the caller merges it in.
module bcd7seg_dec
    import display_scan_ctrl_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [7:0] seg_o
);

    // Table lookup of the segment pattern for one digit
    always_comb begin
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for a bank of common-cathode 7-segment
// digits on one shared segment bus. Each slot starts with BLANK_CYC dead
// cycles (anodes off) followed by the decoded digit. The BCD word is
// snapshotted when scanning starts and again at every frame wrap, so a frame
// never mixes old and new digits.
// Optional feature: define LEADING_ZERO_BLANK_EN to suppress segments A-G of
// leading zero digits (digit 0 is never suppressed).
module display_scan_ctrl
    import display_scan_ctrl_pkg::*;
#(
    parameter int N_DIGITS  = 4,
    parameter int SLOT_CYC  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [4*N_DIGITS-1:0]   digits_bcd,
    input  logic [N_DIGITS-1:0]     dp_mask,
    output logic [7:0]              seg,
    output logic [N_DIGITS-1:0]     an,
    output logic                    frame_done
);

    localparam int CNT_W = $clog2(SLOT_CYC);
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SLOT_CYC - 1);
    localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIGITS - 1);

    // With no dead time a slot opens straight into SHOW
    localparam scan_state_e SLOT_ENTRY = (BLANK_CYC == 0) ? SHOW : BLANK;

    scan_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [3:0]           snap_q [N_DIGITS];
    logic [3:0]           snap_d [N_DIGITS];
    logic [N_DIGITS-1:0]  snap_dp_q, snap_dp_d;
    logic [7:0]           seg_q, seg_d;
    logic [N_DIGITS-1:0]  an_q, an_d;
    logic                 frame_done_q, frame_done_d;

    logic [3:0]           digit_in [N_DIGITS];
    logic [CNT_W-1:0]     cnt_inc;
    logic                 slot_end;
    logic                 frame_wrap;
    logic [3:0]           cur_bcd;
    logic [7:0]           dec_seg;
    logic                 lz_blank;

    // Unpack the BCD input bus into per-digit nibbles
    genvar gi;
    generate
        for (gi = 0; gi < N_DIGITS; gi++) begin : g_unpack
            assign digit_in[gi] = digits_bcd[4*gi +: 4];
        end
    endgenerate

    assign cnt_inc    = cnt_q + 1'b1;
    assign slot_end   = (cnt_q == CNT_LAST);
    assign frame_wrap = slot_end && (idx_q == IDX_LAST);

    // State, counter, index and snapshot registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            snap_dp_q <= '0;
            for (int i = 0; i < N_DIGITS; i++) begin
                snap_q[i] <= 4'd0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            snap_q    <= snap_d;
            snap_dp_q <= snap_dp_d;
        end
    end

    // Next-state logic: slot timing, digit stepping, snapshot capture
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        snap_d    = snap_q;
        snap_dp_d = snap_dp_q;
        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d   = SLOT_ENTRY;
                    cnt_d     = '0;
                    idx_d     = '0;
                    snap_d    = digit_in;
                    snap_dp_d = dp_mask;
                end
                BLANK, SHOW: begin
                    if (slot_end) begin
                        state_d = SLOT_ENTRY;
                        cnt_d   = '0;
                        if (frame_wrap) begin
                            idx_d     = '0;
                            snap_d    = digit_in;
                            snap_dp_d = dp_mask;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d   = cnt_inc;
                        state_d = (cnt_inc < BLANK_LIM) ? BLANK : SHOW;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end
    end

    assign cur_bcd = snap_d[idx_d];

    bcd7seg_dec u_dec (
        .bcd_i (cur_bcd),
        .seg_o (dec_seg)
    );

`ifdef LEADING_ZERO_BLANK_EN
    logic [N_DIGITS-1:0] lz_mask;
    logic                lz_run;

    // Mark digits that are zero and have only zeros above them
    always_comb begin
        lz_mask = '0;
        lz_run  = 1'b1;
        for (int j = N_DIGITS - 1; j >= 1; j--) begin
            lz_run     = lz_run && (snap_d[j] == 4'd0);
            lz_mask[j] = lz_run;
        end
    end

    assign lz_blank = lz_mask[idx_d];
`else
    assign lz_blank = 1'b0;
`endif

    // Output values for the upcoming cycle, registered alongside the state
    always_comb begin
        an_d         = '0;
        seg_d        = SEG_OFF;
        frame_done_d = 1'b0;
        if (state_d == SHOW) begin
            an_d[idx_d]       = 1'b1;
            seg_d             = lz_blank ? SEG_OFF : dec_seg;
            seg_d[SEG_DP_BIT] = snap_dp_d[idx_d];
        end
        if (state_d != IDLE) begin
            frame_done_d = (cnt_d == CNT_LAST) && (idx_d == IDX_LAST);
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q        <= SEG_OFF;
            an_q         <= '0;
            frame_done_q <= 1'b0;
        end else begin
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with N_DIGITS=4, SLOT_CYC=8,
// BLANK_CYC=2. A table of consecutive slots drives the main scan; short
// hand-written sequences cover enable drop and reset mid-frame.
module tb_display_scan_ctrl;

    localparam int N  = 4;
    localparam int SC = 8;
    localparam int BC = 2;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [7:0] F4_D2 = 8'h00;
    localparam logic [7:0] F4_D3 = 8'h01;
`else
    localparam logic [7:0] F4_D2 = 8'hFC;
    localparam logic [7:0] F4_D3 = 8'hFD;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           enable;
    logic [4*N-1:0] digits_bcd;
    logic [N-1:0]   dp_mask;
    logic [7:0]     seg;
    logic [N-1:0]   an;
    logic           frame_done;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic           load;
        logic [4*N-1:0] bcd;
        logic [N-1:0]   dp;
        int             digit;
        logic [7:0]     seg;
    } slot_vec_t;

    slot_vec_t tbl [16];

    display_scan_ctrl #(
        .N_DIGITS  (N),
        .SLOT_CYC  (SC),
        .BLANK_CYC (BC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .digits_bcd (digits_bcd),
        .dp_mask    (dp_mask),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_outputs(input string name, input logic [N-1:0] e_an,
                               input logic [7:0] e_seg, input logic e_fd);
        chk({name, ".an"}, 32'(an), 32'(e_an));
        chk({name, ".seg"}, 32'(seg), 32'(e_seg));
        chk({name, ".frame_done"}, 32'(frame_done), 32'(e_fd));
    endtask

    // Walk one full slot: BC blank cycles then the digit until the slot ends
    task automatic check_slot(input string name, input int digit, input logic [7:0] e_seg);
        logic [N-1:0] e_an;
        e_an = '0;
        e_an[digit] = 1'b1;
        for (int c = 0; c < SC; c++) begin
            step();
            if (c < BC)
                chk_outputs(name, '0, 8'h00, 1'b0);
            else
                chk_outputs(name, e_an, e_seg, (c == SC - 1) && (digit == N - 1));
        end
        $display("slot %s digit=%0d an=%b seg=%h", name, digit, an, seg);
    endtask

    function automatic slot_vec_t mk(input logic ld, input logic [15:0] b,
                                     input logic [3:0] d, input int dg, input logic [7:0] s);
        slot_vec_t v;
        v.load  = ld;
        v.bcd   = b;
        v.dp    = d;
        v.digit = dg;
        v.seg   = s;
        return v;
    endfunction

    initial begin
        // Frame 1: 1234; switch input to 5678 mid-frame (must not tear)
        tbl[0]  = mk(1'b1, 16'h1234, 4'b0000, 0, 8'h66);
        tbl[1]  = mk(1'b1, 16'h5678, 4'b0000, 1, 8'hF2);
        tbl[2]  = mk(1'b0, 16'h0000, 4'b0000, 2, 8'hDA);
        tbl[3]  = mk(1'b0, 16'h0000, 4'b0000, 3, 8'h60);
        // Frame 2: 5678; queue an invalid digit with its DP set
        tbl[4]  = mk(1'b0, 16'h0000, 4'b0000, 0, 8'hFE);
        tbl[5]  = mk(1'b1, 16'h1C34, 4'b0100, 1, 8'hE0);
        tbl[6]  = mk(1'b0, 16'h0000, 4'b0000, 2, 8'hBE);
        tbl[7]  = mk(1'b0, 16'h0000, 4'b0000, 3, 8'hB6);
        // Frame 3: 1C34 with DP on digit 2; queue leading-zero word
        tbl[8]  = mk(1'b0, 16'h0000, 4'b0000, 0, 8'h66);
        tbl[9]  = mk(1'b1, 16'h0070, 4'b1001, 1, 8'hF2);
        tbl[10] = mk(1'b0, 16'h0000, 4'b0000, 2, 8'h01);
        tbl[11] = mk(1'b0, 16'h0000, 4'b0000, 3, 8'h60);
        // Frame 4: 0070 with DP on digits 0 and 3
        tbl[12] = mk(1'b0, 16'h0000, 4'b0000, 0, 8'hFD);
        tbl[13] = mk(1'b0, 16'h0000, 4'b0000, 1, 8'hE0);
        tbl[14] = mk(1'b0, 16'h0000, 4'b0000, 2, F4_D2);
        tbl[15] = mk(1'b0, 16'h0000, 4'b0000, 3, F4_D3);

        rst        = 1'b1;
        enable     = 1'b0;
        digits_bcd = 16'h1234;
        dp_mask    = '0;

        // Reset state
        for (int i = 0; i < 3; i++) begin
            step();
            chk_outputs("reset", '0, 8'h00, 1'b0);
        end
        $display("reset an=%b seg=%h frame_done=%b", an, seg, frame_done);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk_outputs("idle", '0, 8'h00, 1'b0);
        end

        // Table-driven continuous scan
        enable = 1'b1;
        for (int t = 0; t < 16; t++) begin
            if (tbl[t].load) begin
                digits_bcd = tbl[t].bcd;
                dp_mask    = tbl[t].dp;
            end
            check_slot($sformatf("tbl%0d", t), tbl[t].digit, tbl[t].seg);
        end

        // Enable drop during SHOW of digit 2 (frame 5 still holds 0070)
        check_slot("pre_drop0", 0, 8'hFD);
        check_slot("pre_drop1", 1, 8'hE0);
        for (int c = 0; c < BC + 1; c++) step();
        chk("drop.an_before", 32'(an), 32'(4'b0100));
        enable = 1'b0;
        step();
        chk_outputs("drop", '0, 8'h00, 1'b0);
        $display("drop an=%b seg=%h", an, seg);
        digits_bcd = 16'h1234;
        dp_mask    = '0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk_outputs("drop_idle", '0, 8'h00, 1'b0);
        end
        enable = 1'b1;
        check_slot("reen0", 0, 8'h66);
        check_slot("reen1", 1, 8'hF2);
        check_slot("reen2", 2, 8'hDA);

        // Reset pulse during BLANK of digit 3
        step();
        chk_outputs("rst_blank", '0, 8'h00, 1'b0);
        rst = 1'b1;
        step();
        chk_outputs("rst_mid", '0, 8'h00, 1'b0);
        $display("rst_mid an=%b seg=%h frame_done=%b", an, seg, frame_done);
        rst = 1'b0;
        check_slot("post_rst0", 0, 8'h66);
        check_slot("post_rst1", 1, 8'hF2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
